// File: rtl/mixcolumns_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mixcolumns_iter
//  Description : Iterative AES MixColumns stage. Accepts one 128-bit state
//                per handshake, mixes LANES columns per clock in place and
//                presents the result on a registered output handshake.
//                A per-block bypass passes the state through unmixed for
//                the final AES round.
//  Revision    : 1.0 - initial release
// ============================================================================
module mixcolumns_iter #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bypass,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    // Reject unsupported lane counts at elaboration time.
    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
            $error("mixcolumns_iter: LANES must be 1, 2 or 4");
        end
    endgenerate

    // Column index advance per clock, and the index of the final group.
    localparam logic [1:0] c_STEP = 2'(LANES);
    localparam logic [1:0] c_LAST = 2'(4 - LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [127:0]  r_work;
    logic [1:0]    r_idx;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_busy;
    logic [127:0]  r_out;
    logic [127:0]  w_work_next;

    // GF(2^8) multiply-by-2 modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // One MixColumns column; row 0 is the most significant byte.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // Working state with the current column group mixed in place.
    always_comb begin
        w_work_next = r_work;
        for (int l = 0; l < LANES; l++) begin
            w_work_next[127 - 32*(int'(r_idx) + l) -: 32] =
                mix_col(r_work[127 - 32*(int'(r_idx) + l) -: 32]);
        end
    end

    // Control FSM with registered handshake outputs and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_work     <= state_in;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (in_bypass) begin
                            // Final round: no mixing, result visible next cycle.
                            r_out       <= state_in;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_idx   <= '0;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_work <= w_work_next;
                    r_idx  <= r_idx + c_STEP;
                    if (r_idx == c_LAST) begin
                        r_out       <= w_work_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // Input reopens only after the output handshake completes.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign state_out = r_out;
    assign busy      = r_busy;

endmodule
`default_nettype wire
